// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite widths and skid-buffer state type for the PicoRV32 bus slice.
// Pure declarations: no latency and no backpressure of its own.
package axi4_lite_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = 4;
    localparam int AXI_PROT_W = 3;

    localparam int AX_PAYLOAD_W = AXI_ADDR_W + AXI_PROT_W;
    localparam int W_PAYLOAD_W  = AXI_DATA_W + AXI_STRB_W;
    localparam int R_PAYLOAD_W  = AXI_DATA_W;
    // B carries no response field; one constant bit keeps the buffer generic
    localparam int B_PAYLOAD_W  = 1;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/axi_skid_buffer.sv
// Two-entry valid/ready skid buffer: one cycle forward latency, full throughput, or a plain wire when BYPASS.
// Backpressure: in_ready is registered and drops only once the skid entry holds a beat.
module axi_skid_buffer
    import axi4_lite_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter bit BYPASS = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    generate
        if (BYPASS) begin : g_bypass
            assign out_valid = in_valid;
            assign out_data  = in_data;
            assign in_ready  = out_ready;

            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset;
        end else begin : g_skid
            skid_state_e      state_q, state_d;
            logic             in_ready_q;
            logic [WIDTH-1:0] main_q, skid_q;
            logic             in_fire, out_fire;
            logic             load_main_in, load_main_skid, load_skid;

            assign in_fire  = in_valid && in_ready_q;
            assign out_fire = (state_q != SKID_EMPTY) && out_ready;

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q    <= SKID_EMPTY;
                    in_ready_q <= 1'b0;
                end else begin
                    state_q    <= state_d;
                    in_ready_q <= (state_d != SKID_TWO);
                end
            end

            always_comb begin
                state_d        = state_q;
                load_main_in   = 1'b0;
                load_main_skid = 1'b0;
                load_skid      = 1'b0;
                case (state_q)
                    SKID_EMPTY: begin
                        if (in_fire) begin
                            state_d      = SKID_ONE;
                            load_main_in = 1'b1;
                        end
                    end
                    SKID_ONE: begin
                        if (in_fire && out_fire) begin
                            load_main_in = 1'b1;
                        end else if (in_fire) begin
                            // downstream stalled in the same cycle: park the new beat
                            state_d   = SKID_TWO;
                            load_skid = 1'b1;
                        end else if (out_fire) begin
                            state_d = SKID_EMPTY;
                        end
                    end
                    SKID_TWO: begin
                        if (out_fire) begin
                            state_d        = SKID_ONE;
                            load_main_skid = 1'b1;
                        end
                    end
                    default: state_d = SKID_EMPTY;
                endcase
            end

            // payload registers carry no reset; valid qualifies them
            always_ff @(posedge clk) begin
                if (load_main_in) begin
                    main_q <= in_data;
                end else if (load_main_skid) begin
                    main_q <= skid_q;
                end
                if (load_skid) begin
                    skid_q <= in_data;
                end
            end

            assign in_ready  = in_ready_q;
            assign out_valid = (state_q != SKID_EMPTY);
            assign out_data  = main_q;
        end
    endgenerate

endmodule

// File: rtl/axi4_lite_reg_slice.sv
// AXI4-Lite register slice between picorv32_axi and its slave: one cycle per enabled channel, 1 beat/cycle.
// Backpressure: each channel has its own skid buffer, so no ready or valid path crosses the slice combinationally.
module axi4_lite_reg_slice
    import axi4_lite_pkg::*;
#(
    parameter bit REG_AW = 1'b1,
    parameter bit REG_W  = 1'b1,
    parameter bit REG_B  = 1'b1,
    parameter bit REG_AR = 1'b1,
    parameter bit REG_R  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  s_mem_axi_awvalid,
    output logic                  s_mem_axi_awready,
    input  logic [AXI_ADDR_W-1:0] s_mem_axi_awaddr,
    input  logic [AXI_PROT_W-1:0] s_mem_axi_awprot,
    input  logic                  s_mem_axi_wvalid,
    output logic                  s_mem_axi_wready,
    input  logic [AXI_DATA_W-1:0] s_mem_axi_wdata,
    input  logic [AXI_STRB_W-1:0] s_mem_axi_wstrb,
    output logic                  s_mem_axi_bvalid,
    input  logic                  s_mem_axi_bready,
    input  logic                  s_mem_axi_arvalid,
    output logic                  s_mem_axi_arready,
    input  logic [AXI_ADDR_W-1:0] s_mem_axi_araddr,
    input  logic [AXI_PROT_W-1:0] s_mem_axi_arprot,
    output logic                  s_mem_axi_rvalid,
    input  logic                  s_mem_axi_rready,
    output logic [AXI_DATA_W-1:0] s_mem_axi_rdata,

    output logic                  m_mem_axi_awvalid,
    input  logic                  m_mem_axi_awready,
    output logic [AXI_ADDR_W-1:0] m_mem_axi_awaddr,
    output logic [AXI_PROT_W-1:0] m_mem_axi_awprot,
    output logic                  m_mem_axi_wvalid,
    input  logic                  m_mem_axi_wready,
    output logic [AXI_DATA_W-1:0] m_mem_axi_wdata,
    output logic [AXI_STRB_W-1:0] m_mem_axi_wstrb,
    input  logic                  m_mem_axi_bvalid,
    output logic                  m_mem_axi_bready,
    output logic                  m_mem_axi_arvalid,
    input  logic                  m_mem_axi_arready,
    output logic [AXI_ADDR_W-1:0] m_mem_axi_araddr,
    output logic [AXI_PROT_W-1:0] m_mem_axi_arprot,
    input  logic                  m_mem_axi_rvalid,
    output logic                  m_mem_axi_rready,
    input  logic [AXI_DATA_W-1:0] m_mem_axi_rdata
);

    logic [B_PAYLOAD_W-1:0] b_dat_unused;

    axi_skid_buffer #(.WIDTH(AX_PAYLOAD_W), .BYPASS(!REG_AW)) u_aw (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s_mem_axi_awvalid),
        .in_ready  (s_mem_axi_awready),
        .in_data   ({s_mem_axi_awaddr, s_mem_axi_awprot}),
        .out_valid (m_mem_axi_awvalid),
        .out_ready (m_mem_axi_awready),
        .out_data  ({m_mem_axi_awaddr, m_mem_axi_awprot})
    );

    axi_skid_buffer #(.WIDTH(W_PAYLOAD_W), .BYPASS(!REG_W)) u_w (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s_mem_axi_wvalid),
        .in_ready  (s_mem_axi_wready),
        .in_data   ({s_mem_axi_wdata, s_mem_axi_wstrb}),
        .out_valid (m_mem_axi_wvalid),
        .out_ready (m_mem_axi_wready),
        .out_data  ({m_mem_axi_wdata, m_mem_axi_wstrb})
    );

    axi_skid_buffer #(.WIDTH(B_PAYLOAD_W), .BYPASS(!REG_B)) u_b (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (m_mem_axi_bvalid),
        .in_ready  (m_mem_axi_bready),
        .in_data   ({B_PAYLOAD_W{1'b0}}),
        .out_valid (s_mem_axi_bvalid),
        .out_ready (s_mem_axi_bready),
        .out_data  (b_dat_unused)
    );

    axi_skid_buffer #(.WIDTH(AX_PAYLOAD_W), .BYPASS(!REG_AR)) u_ar (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s_mem_axi_arvalid),
        .in_ready  (s_mem_axi_arready),
        .in_data   ({s_mem_axi_araddr, s_mem_axi_arprot}),
        .out_valid (m_mem_axi_arvalid),
        .out_ready (m_mem_axi_arready),
        .out_data  ({m_mem_axi_araddr, m_mem_axi_arprot})
    );

    axi_skid_buffer #(.WIDTH(R_PAYLOAD_W), .BYPASS(!REG_R)) u_r (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (m_mem_axi_rvalid),
        .in_ready  (m_mem_axi_rready),
        .in_data   (m_mem_axi_rdata),
        .out_valid (s_mem_axi_rvalid),
        .out_ready (s_mem_axi_rready),
        .out_data  (s_mem_axi_rdata)
    );

endmodule

// File: tb/tb_axi4_lite_reg_slice.sv
// Scoreboard bench for the AXI4-Lite register slice, plus a second instance with the AR channel wired through.
// Stimulus pushes expected beats; a negedge monitor pops and compares whatever the DUT emits.
module tb_axi4_lite_reg_slice;

    localparam int CH_AW = 0;
    localparam int CH_W  = 1;
    localparam int CH_B  = 2;
    localparam int CH_AR = 3;
    localparam int CH_R  = 4;

    typedef struct {
        logic [63:0] dat;
        int          cyc;
        bit          ex;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    exp_t q [5][$];

    logic        s_awvalid = 0, s_awready;
    logic [31:0] s_awaddr = 0;
    logic [2:0]  s_awprot = 0;
    logic        s_wvalid = 0, s_wready;
    logic [31:0] s_wdata = 0;
    logic [3:0]  s_wstrb = 0;
    logic        s_bvalid, s_bready = 1;
    logic        s_arvalid = 0, s_arready;
    logic [31:0] s_araddr = 0;
    logic [2:0]  s_arprot = 0;
    logic        s_rvalid, s_rready = 1;
    logic [31:0] s_rdata;

    logic        m_awvalid, m_awready = 1;
    logic [31:0] m_awaddr;
    logic [2:0]  m_awprot;
    logic        m_wvalid, m_wready = 1;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_bvalid = 0, m_bready;
    logic        m_arvalid, m_arready = 1;
    logic [31:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_rvalid = 0, m_rready;
    logic [31:0] m_rdata = 0;

    logic        bp_s_arvalid = 0, bp_s_arready, bp_m_arvalid, bp_m_arready = 0;
    logic [31:0] bp_s_araddr = 0, bp_m_araddr;
    logic [2:0]  bp_s_arprot = 0, bp_m_arprot;
    logic        bp_unused_awready, bp_unused_wready, bp_unused_bvalid, bp_unused_rvalid;
    logic [31:0] bp_unused_rdata, bp_unused_awaddr, bp_unused_wdata;
    logic [2:0]  bp_unused_awprot;
    logic [3:0]  bp_unused_wstrb;
    logic        bp_unused_awvalid, bp_unused_wvalid, bp_unused_bready, bp_unused_rready;

    axi4_lite_reg_slice dut (
        .clk(clk), .reset(reset),
        .s_mem_axi_awvalid(s_awvalid), .s_mem_axi_awready(s_awready),
        .s_mem_axi_awaddr(s_awaddr), .s_mem_axi_awprot(s_awprot),
        .s_mem_axi_wvalid(s_wvalid), .s_mem_axi_wready(s_wready),
        .s_mem_axi_wdata(s_wdata), .s_mem_axi_wstrb(s_wstrb),
        .s_mem_axi_bvalid(s_bvalid), .s_mem_axi_bready(s_bready),
        .s_mem_axi_arvalid(s_arvalid), .s_mem_axi_arready(s_arready),
        .s_mem_axi_araddr(s_araddr), .s_mem_axi_arprot(s_arprot),
        .s_mem_axi_rvalid(s_rvalid), .s_mem_axi_rready(s_rready),
        .s_mem_axi_rdata(s_rdata),
        .m_mem_axi_awvalid(m_awvalid), .m_mem_axi_awready(m_awready),
        .m_mem_axi_awaddr(m_awaddr), .m_mem_axi_awprot(m_awprot),
        .m_mem_axi_wvalid(m_wvalid), .m_mem_axi_wready(m_wready),
        .m_mem_axi_wdata(m_wdata), .m_mem_axi_wstrb(m_wstrb),
        .m_mem_axi_bvalid(m_bvalid), .m_mem_axi_bready(m_bready),
        .m_mem_axi_arvalid(m_arvalid), .m_mem_axi_arready(m_arready),
        .m_mem_axi_araddr(m_araddr), .m_mem_axi_arprot(m_arprot),
        .m_mem_axi_rvalid(m_rvalid), .m_mem_axi_rready(m_rready),
        .m_mem_axi_rdata(m_rdata)
    );

    axi4_lite_reg_slice #(.REG_AR(1'b0)) dut_byp (
        .clk(clk), .reset(reset),
        .s_mem_axi_awvalid(s_awvalid), .s_mem_axi_awready(bp_unused_awready),
        .s_mem_axi_awaddr(s_awaddr), .s_mem_axi_awprot(s_awprot),
        .s_mem_axi_wvalid(s_wvalid), .s_mem_axi_wready(bp_unused_wready),
        .s_mem_axi_wdata(s_wdata), .s_mem_axi_wstrb(s_wstrb),
        .s_mem_axi_bvalid(bp_unused_bvalid), .s_mem_axi_bready(s_bready),
        .s_mem_axi_arvalid(bp_s_arvalid), .s_mem_axi_arready(bp_s_arready),
        .s_mem_axi_araddr(bp_s_araddr), .s_mem_axi_arprot(bp_s_arprot),
        .s_mem_axi_rvalid(bp_unused_rvalid), .s_mem_axi_rready(s_rready),
        .s_mem_axi_rdata(bp_unused_rdata),
        .m_mem_axi_awvalid(bp_unused_awvalid), .m_mem_axi_awready(m_awready),
        .m_mem_axi_awaddr(bp_unused_awaddr), .m_mem_axi_awprot(bp_unused_awprot),
        .m_mem_axi_wvalid(bp_unused_wvalid), .m_mem_axi_wready(m_wready),
        .m_mem_axi_wdata(bp_unused_wdata), .m_mem_axi_wstrb(bp_unused_wstrb),
        .m_mem_axi_bvalid(m_bvalid), .m_mem_axi_bready(bp_unused_bready),
        .m_mem_axi_arvalid(bp_m_arvalid), .m_mem_axi_arready(bp_m_arready),
        .m_mem_axi_araddr(bp_m_araddr), .m_mem_axi_arprot(bp_m_arprot),
        .m_mem_axi_rvalid(m_rvalid), .m_mem_axi_rready(bp_unused_rready),
        .m_mem_axi_rdata(m_rdata)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: handshake timed out at cycle %0d", nm, cyc);
    endtask

    task automatic push(input int ch, input logic [63:0] d, input bit ex);
        exp_t e;
        e.dat = d;
        e.cyc = cyc;
        e.ex  = ex;
        q[ch].push_back(e);
    endtask

    task automatic pop_cmp(input int ch, input string nm, input logic [63:0] act);
        exp_t e;
        n_cmp++;
        if (q[ch].size() == 0) begin
            n_err++;
            $display("FAIL %s: unexpected beat %h at cycle %0d, none outstanding", nm, act, cyc);
        end else begin
            e = q[ch].pop_front();
            if (act !== e.dat || (e.ex && cyc != e.cyc + 1)) begin
                n_err++;
                $display("FAIL %s: got %h at cycle %0d, expected %h (accepted cycle %0d, exact=%0d)",
                         nm, act, cyc, e.dat, e.cyc, e.ex);
            end
        end
    endtask

    function automatic int qsz();
        int s = 0;
        for (int i = 0; i < 5; i++) s += q[i].size();
        return s;
    endfunction

    // monitor: pops on every emitted beat and checks stability while stalled
    logic        ar_hold = 0, r_hold = 0;
    logic [63:0] ar_held = 0, r_held = 0;
    int          ar_cnt = 0, ar_first = 0, ar_last = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (m_awvalid && m_awready) pop_cmp(CH_AW, "m_aw", {29'b0, m_awaddr, m_awprot});
            if (m_wvalid && m_wready)   pop_cmp(CH_W, "m_w", {28'b0, m_wdata, m_wstrb});
            if (s_bvalid && s_bready)   pop_cmp(CH_B, "s_b", 64'd0);
            if (s_rvalid && s_rready)   pop_cmp(CH_R, "s_r", {32'b0, s_rdata});
            if (m_arvalid && m_arready) begin
                pop_cmp(CH_AR, "m_ar", {29'b0, m_araddr, m_arprot});
                ar_cnt++;
                if (ar_cnt == 1) ar_first = cyc;
                ar_last = cyc;
            end
            if (ar_hold) chk("m_ar_stable", {m_arvalid, 28'b0, m_araddr, m_arprot}, {1'b1, ar_held[62:0]});
            if (r_hold)  chk("s_r_stable", {s_rvalid, 31'b0, s_rdata}, {1'b1, r_held[62:0]});
            ar_hold = m_arvalid && !m_arready;
            ar_held = {29'b0, m_araddr, m_arprot};
            r_hold  = s_rvalid && !s_rready;
            r_held  = {32'b0, s_rdata};
        end else begin
            ar_hold = 1'b0;
            r_hold  = 1'b0;
        end
    end

    task automatic send_ar(input logic [31:0] a, input logic [2:0] p, input bit ex);
        int t = 0;
        s_arvalid = 1; s_araddr = a; s_arprot = p;
        forever begin
            @(negedge clk);
            if (s_arready) break;
            if (++t > 100) begin timeout_fail("ar_accept"); break; end
        end
        if (s_arready) push(CH_AR, {29'b0, a, p}, ex);
        @(posedge clk); #1;
        s_arvalid = 0;
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [2:0] p, input bit ex);
        int t = 0;
        s_awvalid = 1; s_awaddr = a; s_awprot = p;
        forever begin
            @(negedge clk);
            if (s_awready) break;
            if (++t > 100) begin timeout_fail("aw_accept"); break; end
        end
        if (s_awready) push(CH_AW, {29'b0, a, p}, ex);
        @(posedge clk); #1;
        s_awvalid = 0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input bit ex);
        int t = 0;
        s_wvalid = 1; s_wdata = d; s_wstrb = s;
        forever begin
            @(negedge clk);
            if (s_wready) break;
            if (++t > 100) begin timeout_fail("w_accept"); break; end
        end
        if (s_wready) push(CH_W, {28'b0, d, s}, ex);
        @(posedge clk); #1;
        s_wvalid = 0;
    endtask

    task automatic send_b(input bit ex);
        int t = 0;
        m_bvalid = 1;
        forever begin
            @(negedge clk);
            if (m_bready) break;
            if (++t > 100) begin timeout_fail("b_accept"); break; end
        end
        if (m_bready) push(CH_B, 64'd0, ex);
        @(posedge clk); #1;
        m_bvalid = 0;
    endtask

    task automatic send_r(input logic [31:0] d);
        int t = 0;
        m_rvalid = 1; m_rdata = d;
        forever begin
            @(negedge clk);
            if (m_rready) break;
            if (++t > 100) begin timeout_fail("r_accept"); break; end
        end
        if (m_rready) push(CH_R, {32'b0, d}, 1'b0);
        @(posedge clk); #1;
        m_rvalid = 0;
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while (qsz() != 0 && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        if (qsz() != 0) timeout_fail(nm);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish by cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    bit rnd_done = 0;

    initial begin
        // reset held 5 cycles with AW pending upstream
        s_awvalid = 1; s_awaddr = 32'h0000_00A0; s_awprot = 3'b000;
        repeat (5) begin
            @(negedge clk);
            chk("reset_hold", 64'({s_awready, s_wready, s_arready, m_bready, m_rready,
                                  m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid}), 64'd0);
        end
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("release_cycle1", 64'({s_awready, s_wready, s_arready, m_bready, m_rready,
                                  m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid}), 64'd0);
        @(negedge clk);
        chk("release_cycle2_ready", 64'({s_awready, s_wready, s_arready, m_bready, m_rready}), 64'h1F);
        if (s_awready) push(CH_AW, {29'b0, 32'h0000_00A0, 3'b000}, 1'b1);
        @(posedge clk); #1;
        s_awvalid = 0;
        drain("reset_aw_drain");

        // write path: AW then W three cycles later, then one B back
        send_aw(32'h1000_0000, 3'b000, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        send_w(32'h0000_0041, 4'b0001, 1'b1);
        drain("write_drain");
        send_b(1'b1);
        drain("b_drain");

        // streaming AR: 16 reads, one per cycle
        for (int i = 0; i < 16; i++) send_ar(32'(i * 4), 3'(i), 1'b1);
        drain("ar_stream_drain");
        chk("ar_stream_count", 64'(ar_cnt), 64'd16);
        chk("ar_stream_span", 64'(ar_last - ar_first), 64'd15);

        // skid: downstream stalls in the cycle the second beat is accepted
        s_arvalid = 1; s_araddr = 32'h0000_0100; s_arprot = 3'b000;
        @(negedge clk);
        chk("bp_accept0", 64'(s_arready), 64'd1);
        if (s_arready) push(CH_AR, {29'b0, 32'h0000_0100, 3'b000}, 1'b0);
        @(posedge clk); #1;
        s_araddr = 32'h0000_0104; m_arready = 0;
        @(negedge clk);
        chk("bp_accept1", 64'(s_arready), 64'd1);
        if (s_arready) push(CH_AR, {29'b0, 32'h0000_0104, 3'b000}, 1'b0);
        @(posedge clk); #1;
        s_arvalid = 0;
        repeat (2) begin
            @(negedge clk);
            chk("bp_stall_ready", 64'(s_arready), 64'd0);
            chk("bp_stall_head", {31'b0, m_arvalid, m_araddr}, {31'b0, 1'b1, 32'h0000_0100});
            @(posedge clk); #1;
        end
        m_arready = 1;
        drain("bp_drain");

        // R channel with master ready toggling
        fork
            begin
                send_r(32'hDEAD_BEEF);
                send_r(32'h1234_5678);
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    s_rready = !i[0];
                    @(posedge clk); #1;
                end
                s_rready = 1;
            end
        join
        drain("r_drain");

        // random downstream stalls on AR
        fork
            begin
                for (int i = 0; i < 40; i++) send_ar(32'h0000_0200 + 32'(i * 4), 3'(i), 1'b0);
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    m_arready = 1'($urandom_range(0, 1));
                end
                m_arready = 1;
            end
        join
        drain("rnd_drain");
        chk("all_queues_empty", 64'(qsz()), 64'd0);

        // wire-through AR instance must be purely combinational
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            bp_s_arvalid = 1'($urandom_range(0, 1));
            bp_m_arready = 1'($urandom_range(0, 1));
            bp_s_araddr  = $urandom;
            bp_s_arprot  = 3'($urandom_range(0, 7));
            @(negedge clk);
            chk("bypass_ar", {28'b0, bp_m_arvalid, bp_s_arready, bp_m_araddr, bp_m_arprot},
                             {28'b0, bp_s_arvalid, bp_m_arready, bp_s_araddr, bp_s_arprot});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
